// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg
//   Shared types and constants for the video-memory arbiter.
//   - own_e       : owner of the memory issue slot (also used as the read-return tag)
//   - VRAM_ADDR_W : default memory address width
//   - VRAM_DATA_W : default memory data width
//   - is_host()   : true for either host owner state
package vram_arb_pkg;

  localparam int unsigned VRAM_ADDR_W = 14;
  localparam int unsigned VRAM_DATA_W = 1;

  typedef enum logic [1:0] {
    OWN_NONE    = 2'd0,
    OWN_VID     = 2'd1,
    OWN_HOST_WR = 2'd2,
    OWN_HOST_RD = 2'd3
  } own_e;

  function automatic logic is_host(input own_e own);
    return (own == OWN_HOST_WR) || (own == OWN_HOST_RD);
  endfunction

endpackage

// File: rtl/vram_arb_starve_mon.sv
// vram_arb_starve_mon
//   Host starvation monitor: a saturating count of edges on which the host
//   was requesting but not granted, plus a sticky flag that sets when the
//   count reaches STARVE_MAX+1. Only rst clears the flag.
// Ports
//   clk         in  system clock
//   rst         in  synchronous active-high reset
//   host_req    in  host request level
//   host_grant  in  host granted on this edge
//   host_starve out sticky starvation flag
module vram_arb_starve_mon #(
  parameter int unsigned STARVE_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic host_req,
  input  logic host_grant,
  output logic host_starve
);

  localparam int unsigned    CNT_W   = $clog2(STARVE_MAX + 2);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(STARVE_MAX + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             starve_q, starve_d;

  always_comb begin
    cnt_d = cnt_q;
    if (host_grant) begin
      cnt_d = '0;
    end else if (host_req && (cnt_q != CNT_SAT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // Flag sets on the same edge the count saturates.
    starve_d = starve_q | (cnt_d == CNT_SAT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      starve_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end

  assign host_starve = starve_q;

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Single-port video-memory arbiter. Video fetches always win the issue
//   slot; the host is served in free slots via a req/ack handshake, at most
//   one command every two cycles. Memory command outputs are registered;
//   read data is passed straight through from mem_rdata and qualified by a
//   one-deep return tag (previous owner).
//   Build option VRAM_ARB_HOST_READ_EN: adds host_rdata/host_rvalid and lets
//   host reads reach memory. Without it a host read is acked and dropped.
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   vid_req/vid_addr                video fetch request (pulse) and address
//   vid_data/vid_valid              video read data and its qualifier
//   host_req/we/addr/wdata          host command, held until host_ack
//   host_ack                        host command is on the memory port
//   host_rdata/host_rvalid          host read return (read build only)
//   host_starve                     sticky host starvation flag
//   mem_addr/mem_we/mem_wdata       registered memory command
//   mem_rdata                       synchronous-read memory data
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = VRAM_ADDR_W,
  parameter int unsigned DATA_W     = VRAM_DATA_W,
  parameter int unsigned STARVE_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
`ifdef VRAM_ARB_HOST_READ_EN
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
`endif
  output logic              host_starve,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  own_e              own_q, own_d;
  own_e              ret_q;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              host_grant;

  assign host_ack = is_host(own_q);

  // A held request is already on the port while host_ack is high, so it
  // must not be granted a second time on that edge.
  assign host_grant = !vid_req && host_req && !host_ack;

  always_comb begin
    own_d       = OWN_NONE;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;

    if (vid_req) begin
      own_d = OWN_VID;
    end else if (host_grant) begin
      own_d = host_we ? OWN_HOST_WR : OWN_HOST_RD;
    end

    case (own_d)
      OWN_VID: begin
        mem_addr_d = vid_addr;
      end
      OWN_HOST_WR: begin
        mem_addr_d  = host_addr;
        mem_wdata_d = host_wdata;
        mem_we_d    = 1'b1;
      end
      OWN_HOST_RD: begin
`ifdef VRAM_ARB_HOST_READ_EN
        mem_addr_d  = host_addr;
        mem_wdata_d = host_wdata;
`endif
        // Without host reads the slot still acks, but the memory port idles.
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      own_q       <= OWN_NONE;
      ret_q       <= OWN_NONE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
    end else begin
      own_q       <= own_d;
      ret_q       <= own_q;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;

  assign vid_data  = mem_rdata;
  assign vid_valid = (ret_q == OWN_VID);

`ifdef VRAM_ARB_HOST_READ_EN
  assign host_rdata  = mem_rdata;
  assign host_rvalid = (ret_q == OWN_HOST_RD);
`endif

  vram_arb_starve_mon #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_mon (
    .clk         (clk),
    .rst         (rst),
    .host_req    (host_req),
    .host_grant  (host_grant),
    .host_starve (host_starve)
  );

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port video-memory arbiter that shares the 14-bit-address pixel/glyph memory between the VGA pixel-fetch path and a host write/read port. It sits between the VGA controller's `addr`/`data` pair and the memory instance. It issues at most one memory command per `clk` cycle. Video fetches always have priority, and the host is served in the remaining slots through a req/ack handshake. A saturating wait counter flags host starvation.

## Interface
- `ADDR_W`, default 14: memory address width.
- `DATA_W`, default 1: memory data width.
- `STARVE_MAX`, default 15: host wait cycles tolerated before `host_starve` sets.
- `clk`  in  1  system clock, 50 MHz; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `vid_req`  in  1  video fetch request, one-cycle pulse.
- `vid_addr`  in  ADDR_W  video fetch address.
- `vid_data`  out  DATA_W  video read data; combinational pass-through of `mem_rdata`.
- `vid_valid`  out  1  `vid_data` is valid this cycle.
- `host_req`  in  1  host command request; held until acked.
- `host_we`  in  1  1 selects write, 0 selects read.
- `host_addr`  in  ADDR_W  host address.
- `host_wdata`  in  DATA_W  host write data.
- `host_ack`  out  1  one-cycle pulse: the host command is on the memory port this cycle.
- `host_rdata`  out  DATA_W  host read data, pass-through of `mem_rdata` (`VRAM_ARB_HOST_READ_EN` only).
- `host_rvalid`  out  1  `host_rdata` is valid (`VRAM_ARB_HOST_READ_EN` only).
- `host_starve`  out  1  sticky starvation flag.
- `mem_addr`  out  ADDR_W  registered memory address.
- `mem_we`  out  1  registered memory write enable.
- `mem_wdata`  out  DATA_W  registered memory write data.
- `mem_rdata`  in  DATA_W  synchronous-read data, valid one cycle after its address.

## Operation
- Issue-slot owner register `own`, updated every edge. States: `OWN_NONE`, `OWN_VID`, `OWN_HOST_WR`, `OWN_HOST_RD`. Transitions:
  - `rst` → `OWN_NONE`.
  - else `vid_req` → `OWN_VID`.
  - else `host_req && !host_ack` → `OWN_HOST_WR` if `host_we`, otherwise `OWN_HOST_RD`.
  - else → `OWN_NONE`.
- `mem_addr`, `mem_we` and `mem_wdata` are registered on the same edge from the winning requester.
  - In `OWN_NONE`, `mem_addr` and `mem_wdata` hold their previous values and `mem_we` = 0.
  - `mem_we` is 1 only in `OWN_HOST_WR`.
- `host_ack` = (`own` is a host state). Blocking a host grant while `host_ack` is high prevents double issue of a held request. The host therefore gets at most one command every 2 cycles.
- Read-return pipeline register `ret` = previous `own`:
  - `vid_valid` = (`ret` == `OWN_VID`).
  - `host_rvalid` = (`ret` == `OWN_HOST_RD`).
- Simultaneous `vid_req` and `host_req`: video wins, and the host stays pending with no lost request.
- Starvation counter:
  - Increments on every edge where `host_req` is high and no host grant is made; saturates at `STARVE_MAX`+1.
  - Cleared on a host grant.
  - `host_starve` sets when the counter reaches `STARVE_MAX`+1 and is cleared only by `rst`.
- `vid_req` on consecutive cycles is legal; the host simply waits.

## Timing
- Video request sampled at edge E:
  - Command is on `mem_*` during cycle E..E+1.
  - `vid_valid` is high during cycle E+1..E+2.
  - Latency is fixed at 2 edges.
- Host command granted at edge E:
  - `host_ack` is high for cycle E..E+1.
  - The host may change `host_req` and its fields after edge E+1.
  - `host_rvalid` is high during cycle E+1..E+2.
- Reset values: `mem_addr` 0, `mem_we` 0, `mem_wdata` 0, `vid_valid` 0, `host_ack` 0, `host_rvalid` 0, `host_starve` 0, `own`/`ret` `OWN_NONE`, counter 0.
- Reset mid-operation:
  - In-flight reads are discarded; no valid asserts after the reset edge.
  - A host request still held is granted normally after reset releases.
- Pass-through outputs `vid_data` and `host_rdata` are not reset.

## Configuration
- `VRAM_ARB_HOST_READ_EN` defined:
  - `host_rdata` and `host_rvalid` exist.
  - `OWN_HOST_RD` issues a memory read.
- Undefined:
  - Those ports are absent.
  - A host request with `host_we`=0 is acked and dropped: `own` goes to `OWN_NONE` semantics with `mem_we` 0, and memory is unchanged.

## Structure
- Package `vram_arb_pkg` holds:
  - the owner enum (`OWN_NONE`, `OWN_VID`, `OWN_HOST_WR`, `OWN_HOST_RD`);
  - default `ADDR_W`/`DATA_W` constants.
- One sub-module, `vram_arb_starve_mon`: the saturating counter plus the sticky flag, parameterised by `STARVE_MAX`.

## Test plan
- Video only: `vid_req` at edges 0, 2, 4 with addresses 0x2200, 0x2201, 0x2202; memory model preloaded 1,0,1 → `vid_valid` high during cycles 2, 4, 6 with `vid_data` 1,0,1.
- Collision: `vid_req` (addr 0x2200) and `host_req` (we=1, addr 0x0010, wdata 1) both at edge N → `mem_addr`=0x2200 in cycle N+1; `mem_addr`=0x0010 with `mem_we`=1 and `host_ack`=1 in cycle N+2.
- Host read (macro on): write 1 to 0x0005, then read 0x0005 → `host_rvalid` high one cycle after that `host_ack`, `host_rdata`=1, `vid_valid` stays 0.
- Starvation (`STARVE_MAX`=15): `vid_req` held high for 20 cycles with `host_req` pending → `host_starve` rises after the 16th blocked edge; host acked the cycle after `vid_req` drops; flag stays 1 until `rst`.
- Reset mid-read: `vid_req` at edge E, `rst` high at edge E+1 → `vid_valid` never asserts; all registered outputs 0 the cycle after E+1.
- Macro off: host request with we=0 to 0x0005 → `host_ack` pulses, `mem_we`=0 throughout, memory contents unchanged.
